// File: rtl/core_done_monitor.sv
// End-of-program monitor: latches per-core ENDOP completion with its cycle number,
// then halts after a drain period once every core is done, or flags a timeout.
module core_done_monitor #(
   parameter int NUM_CORES      = 4,
   parameter int INS_WIDTH      = 8,
   parameter int ENDOP_CODE     = 28,
   parameter int CYC_WIDTH      = 32,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int DRAIN_CYCLES   = 5,
   parameter int SEL_WIDTH      = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [NUM_CORES*INS_WIDTH-1:0] ins_bus,
   output logic [NUM_CORES-1:0]           core_done,
   output logic                           all_done,
   output logic                           halt,
   output logic                           timeout,
   output logic                           busy,
   output logic [CYC_WIDTH-1:0]           cycle_count,
   input  logic [SEL_WIDTH-1:0]           sel_core,
   output logic [CYC_WIDTH-1:0]           sel_cycle
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE,
      ST_TIMEOUT
   } state_t;

   localparam int                   DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DW-1:0]        DRAIN_LOAD = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
   localparam logic [CYC_WIDTH-1:0] LIMIT      = CYC_WIDTH'(TIMEOUT_CYCLES - 1);

   state_t                 state_q, state_d;
   logic [NUM_CORES-1:0]   hit;
   logic                   complete;
   logic                   at_limit;
   logic                   launch;
   logic [DW-1:0]          drain_cnt;
   logic [CYC_WIDTH-1:0]   finish [NUM_CORES];

   // A hit is a core showing ENDOP for the first time; later ENDOPs are ignored.
   always_comb begin
      hit = '0;
      for (int i = 0; i < NUM_CORES; i++)
         hit[i] = (ins_bus[i*INS_WIDTH +: INS_WIDTH] == INS_WIDTH'(ENDOP_CODE)) && !core_done[i];
   end

   assign complete = (state_q == ST_RUN) && (&(core_done | hit));
   assign at_limit = (state_q == ST_RUN) && (cycle_count == LIMIT);
   assign launch   = start && (state_q inside {ST_IDLE, ST_DONE, ST_TIMEOUT});

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE, ST_TIMEOUT:
            if (start) state_d = ST_RUN;
         ST_RUN:
            if (complete)      state_d = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
            else if (at_limit) state_d = ST_TIMEOUT;
         ST_DRAIN:
            if (drain_cnt == '0) state_d = ST_DONE;
         default:
            state_d = ST_IDLE;
      endcase
   end

   // NOTE: every output gets a default first so the decode cannot infer a latch.
   always_comb begin
      halt    = 1'b0;
      timeout = 1'b0;
      busy    = 1'b0;
      case (state_q)
         ST_RUN, ST_DRAIN: busy    = 1'b1;
         ST_DONE:          halt    = 1'b1;
         ST_TIMEOUT:       timeout = 1'b1;
         default:          ;
      endcase
   end

   // NOTE: the finish registers are reset too, since reset must leave no trace of a prior run.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         core_done   <= '0;
         all_done    <= 1'b0;
         cycle_count <= '0;
         drain_cnt   <= '0;
         for (int i = 0; i < NUM_CORES; i++) finish[i] <= '0;
      end else begin
         all_done <= 1'b0;
         if (launch) begin
            core_done   <= '0;
            cycle_count <= '0;
            for (int i = 0; i < NUM_CORES; i++) finish[i] <= '0;
         end else if (state_q == ST_RUN) begin
            cycle_count <= cycle_count + CYC_WIDTH'(1);
            core_done   <= core_done | hit;
            all_done    <= complete;
            for (int i = 0; i < NUM_CORES; i++)
               if (hit[i]) finish[i] <= cycle_count;
            if (complete) drain_cnt <= DRAIN_LOAD;
         end else if (state_q == ST_DRAIN && drain_cnt != '0) begin
            drain_cnt <= drain_cnt - DW'(1);
         end
      end
   end

   // Out-of-range selects read as zero.
   always_comb begin
      sel_cycle = '0;
      for (int i = 0; i < NUM_CORES; i++)
         if (32'(sel_core) == i) sel_cycle = finish[i];
   end

endmodule

// File: tb/tb_core_done_monitor.sv
// Directed bench for core_done_monitor: defaults, a short-timeout instance and
// an 8-core zero-drain instance, all sharing one clock.
module tb_core_done_monitor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // d0: defaults
   logic        rst0, start0;
   logic [31:0] ins0;
   logic [3:0]  sel0, cd0;
   logic        ad0, halt0, to0, busy0;
   logic [31:0] cc0, sc0;

   // d1: TIMEOUT_CYCLES = 50
   logic        rst1, start1;
   logic [31:0] ins1;
   logic [3:0]  sel1, cd1;
   logic        ad1, halt1, to1, busy1;
   logic [31:0] cc1, sc1;

   // d2: 8 cores, DRAIN_CYCLES = 0
   logic        rst2, start2;
   logic [63:0] ins2;
   logic [3:0]  sel2;
   logic [7:0]  cd2;
   logic        ad2, halt2, to2, busy2;
   logic [31:0] cc2, sc2;

   core_done_monitor u_d0 (
      .clk(clk), .rst(rst0), .start(start0), .ins_bus(ins0),
      .core_done(cd0), .all_done(ad0), .halt(halt0), .timeout(to0), .busy(busy0),
      .cycle_count(cc0), .sel_core(sel0), .sel_cycle(sc0)
   );

   core_done_monitor #(.TIMEOUT_CYCLES(50)) u_d1 (
      .clk(clk), .rst(rst1), .start(start1), .ins_bus(ins1),
      .core_done(cd1), .all_done(ad1), .halt(halt1), .timeout(to1), .busy(busy1),
      .cycle_count(cc1), .sel_core(sel1), .sel_cycle(sc1)
   );

   core_done_monitor #(.NUM_CORES(8), .DRAIN_CYCLES(0)) u_d2 (
      .clk(clk), .rst(rst2), .start(start2), .ins_bus(ins2),
      .core_done(cd2), .all_done(ad2), .halt(halt2), .timeout(to2), .busy(busy2),
      .cycle_count(cc2), .sel_core(sel2), .sel_cycle(sc2)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          fin [4];
      int          sels [5];
      int          sexp [5];
      logic [3:0]  exp_cd;

      fin  = '{10, 40, 25, 60};
      sels = '{0, 1, 2, 3, 5};
      sexp = '{10, 40, 25, 60, 0};

      rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
      start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
      ins0 = '0; ins1 = '0; ins2 = '0;
      sel0 = '0; sel1 = '0; sel2 = '0;

      // reset state
      #12;
      check("rst_core_done", cd0, 0);
      check("rst_all_done", ad0, 0);
      check("rst_halt", halt0, 0);
      check("rst_timeout", to0, 0);
      check("rst_busy", busy0, 0);
      check("rst_cycle", cc0, 0);
      check("rst_sel_cycle", sc0, 0);
      tick();
      rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
      ins0 = {4{8'd1}}; ins1 = {4{8'd1}}; ins2 = {8{8'd1}};
      tick();

      // reset mid-run clears everything immediately
      start0 = 1'b1; tick(); start0 = 1'b0;
      check("mid_busy_up", busy0, 1);
      for (int k = 0; k < 5; k++) begin
         ins0[7:0] = (k == 2) ? 8'd28 : 8'd1;
         tick();
      end
      check("mid_core_done", cd0, 4'b0001);
      check("mid_cycle", cc0, 5);
      check("mid_finish0", sc0, 2);
      #2 rst0 = 1'b1;
      #1;
      check("mid_rst_core_done", cd0, 0);
      check("mid_rst_busy", busy0, 0);
      check("mid_rst_cycle", cc0, 0);
      check("mid_rst_finish0", sc0, 0);
      tick();
      rst0 = 1'b0;
      ins0 = {4{8'd1}};
      tick(); tick(); tick();
      check("idle_after_rst_busy", busy0, 0);
      check("idle_after_rst_cycle", cc0, 0);

      // staggered finish
      start0 = 1'b1; tick(); start0 = 1'b0;
      for (int k = 0; k <= 60; k++) begin
         for (int i = 0; i < 4; i++) ins0[i*8 +: 8] = (k == fin[i]) ? 8'd28 : 8'd1;
         tick();
         exp_cd = '0;
         for (int i = 0; i < 4; i++) if (fin[i] <= k) exp_cd[i] = 1'b1;
         check($sformatf("stag_cd_k%0d", k), cd0, exp_cd);
         check($sformatf("stag_ad_k%0d", k), ad0, (k == 60));
      end
      ins0 = {4{8'd1}};
      check("stag_cycle_frozen", cc0, 61);
      check("stag_busy_drain", busy0, 1);
      for (int j = 1; j <= 5; j++) begin
         start0 = (j == 2);
         tick();
         start0 = 1'b0;
         check($sformatf("drain_halt_j%0d", j), halt0, (j == 5));
         check($sformatf("drain_busy_j%0d", j), busy0, (j < 5));
         check($sformatf("drain_ad_j%0d", j), ad0, 0);
         check($sformatf("drain_cycle_j%0d", j), cc0, 61);
      end
      for (int s = 0; s < 5; s++) begin
         sel0 = 4'(sels[s]);
         #1;
         check($sformatf("stag_sel%0d", sels[s]), sc0, sexp[s]);
      end
      tick(); tick(); tick();
      check("done_halt_hold", halt0, 1);
      check("done_cycle_hold", cc0, 61);
      check("done_core_done_hold", cd0, 4'b1111);

      // start in DONE restarts cleared, then all cores finish on the first edge
      sel0 = '0;
      start0 = 1'b1; tick(); start0 = 1'b0;
      check("restart_core_done", cd0, 0);
      check("restart_halt", halt0, 0);
      check("restart_cycle", cc0, 0);
      check("restart_finish0", sc0, 0);
      check("restart_busy", busy0, 1);
      ins0 = {4{8'd28}};
      tick();
      ins0 = {4{8'd1}};
      check("simul_core_done", cd0, 4'b1111);
      check("simul_all_done", ad0, 1);
      check("simul_cycle", cc0, 1);
      for (int s = 0; s < 4; s++) begin
         sel0 = 4'(s);
         #1;
         check($sformatf("simul_finish%0d", s), sc0, 0);
      end
      tick();
      check("simul_ad_drop", ad0, 0);
      tick(); tick(); tick(); tick();
      check("simul_halt", halt0, 1);

      // sticky flag: core 0 holds ENDOP for 10 cycles, others finish at 20
      sel0 = '0;
      start0 = 1'b1; tick(); start0 = 1'b0;
      for (int k = 0; k <= 20; k++) begin
         ins0[7:0] = (k >= 3 && k <= 12) ? 8'd28 : 8'd1;
         for (int i = 1; i < 4; i++) ins0[i*8 +: 8] = (k == 20) ? 8'd28 : 8'd1;
         tick();
         if (k == 15) begin
            check("sticky_core_done", cd0, 4'b0001);
            check("sticky_finish0", sc0, 3);
         end
      end
      ins0 = {4{8'd1}};
      check("sticky_all_done", ad0, 1);
      check("sticky_core_done_all", cd0, 4'b1111);
      check("sticky_finish0_final", sc0, 3);
      sel0 = 4'd1;
      #1;
      check("sticky_finish1", sc0, 20);

      // timeout: core 3 never finishes
      start1 = 1'b1; tick(); start1 = 1'b0;
      ins1 = {8'd1, 8'd28, 8'd28, 8'd28};
      for (int j = 1; j <= 50; j++) begin
         tick();
         check($sformatf("to_flag_j%0d", j), to1, (j == 50));
         check($sformatf("to_busy_j%0d", j), busy1, (j < 50));
      end
      check("to_core_done", cd1, 4'b0111);
      check("to_halt", halt1, 0);
      check("to_cycle", cc1, 50);
      check("to_all_done", ad1, 0);

      // completion on the limit edge beats timeout
      ins1 = {4{8'd1}};
      start1 = 1'b1; tick(); start1 = 1'b0;
      check("to_restart_flag", to1, 0);
      check("to_restart_core_done", cd1, 0);
      for (int k = 0; k <= 49; k++) begin
         ins1[31:24] = (k == 49) ? 8'd28 : 8'd1;
         for (int i = 0; i < 3; i++) ins1[i*8 +: 8] = (k == 5) ? 8'd28 : 8'd1;
         tick();
      end
      ins1 = {4{8'd1}};
      check("edge_all_done", ad1, 1);
      check("edge_timeout", to1, 0);
      check("edge_busy", busy1, 1);
      check("edge_core_done", cd1, 4'b1111);
      sel1 = 4'd3;
      #1;
      check("edge_finish3", sc1, 49);
      tick(); tick(); tick(); tick(); tick();
      check("edge_halt", halt1, 1);
      check("edge_timeout_late", to1, 0);

      // 8 cores, zero drain: halt and all_done rise together
      start2 = 1'b1; tick(); start2 = 1'b0;
      for (int k = 0; k <= 14; k++) begin
         for (int i = 0; i < 8; i++) ins2[i*8 +: 8] = (k == 2*i) ? 8'd28 : 8'd1;
         tick();
         check($sformatf("d0_ad_k%0d", k), ad2, (k == 14));
         check($sformatf("d0_halt_k%0d", k), halt2, (k == 14));
      end
      ins2 = {8{8'd1}};
      check("d0_core_done", cd2, 8'hff);
      check("d0_busy", busy2, 0);
      tick();
      check("d0_ad_drop", ad2, 0);
      check("d0_halt_hold", halt2, 1);
      sel2 = 4'd7;
      #1;
      check("d0_finish7", sc2, 14);
      sel2 = 4'd3;
      #1;
      check("d0_finish3", sc2, 6);
      sel2 = 4'd9;
      #1;
      check("d0_sel_oor", sc2, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/core_done_monitor.md
# core_done_monitor

Synthesizable end-of-program monitor for the multi-core multiplier processor, generalising the bench-side "all cores reached ENDOP" check into RTL. It watches each core's current instruction byte, latches a sticky per-core done flag with the finishing cycle number, raises a halt after a configurable drain period once every core has finished, and flags a timeout if they have not. It sits beside the processor top, fed by the per-core `ins` outputs, and drives halt/status to the host or a bench.

## Interface
- `NUM_CORES`, default 4: number of monitored cores; range 1–16.
- `INS_WIDTH`, default 8: instruction byte width per core.
- `ENDOP_CODE`, default 28: opcode value meaning "core finished".
- `CYC_WIDTH`, default 32: width of the cycle counter and finish-cycle registers.
- `TIMEOUT_CYCLES`, default 100000: RUN cycles allowed before timeout; must be < 2^CYC_WIDTH and ≥ 1.
- `DRAIN_CYCLES`, default 5: cycles between all-done and halt; 0 allowed.
- `SEL_WIDTH`, default 4: width of the core-select input.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle pulse that begins a run.
- `ins_bus` input NUM_CORES*INS_WIDTH: core i's instruction at bits [i*INS_WIDTH +: INS_WIDTH].
- `core_done` output NUM_CORES: sticky per-core finished flags.
- `all_done` output 1: one-cycle pulse when the last core finishes.
- `halt` output 1: level, high in DONE.
- `timeout` output 1: level, high in TIMEOUT.
- `busy` output 1: high in RUN or DRAIN.
- `cycle_count` output CYC_WIDTH: RUN cycle counter.
- `sel_core` input SEL_WIDTH: finish-cycle readout select.
- `sel_cycle` output CYC_WIDTH: finish cycle of `sel_core`.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE, TIMEOUT. Reset → IDLE. On reset, every register output is 0: `core_done`, `all_done`, `halt`, `timeout`, `busy`, `cycle_count`, and all finish-cycle registers.
- IDLE/DONE/TIMEOUT + `start` → RUN. The same edge clears `core_done`, the finish registers, `cycle_count`, `halt` and `timeout`. `start` in RUN or DRAIN is ignored.
- RUN:
  - Each edge, for each core i with `ins_i == ENDOP_CODE` and `core_done[i]==0`: set `core_done[i]` and load `finish[i] <= cycle_count`.
  - `cycle_count` increments every RUN edge.
  - Once done, a core's flag stays set even if its instruction changes or ENDOP repeats.
- Completion: if the OR of the current `core_done` and this edge's new hits is all-ones, then:
  - `all_done` pulses for one cycle.
  - The FSM goes to DRAIN, or directly to DONE when `DRAIN_CYCLES==0`.
- Timeout: in RUN, an edge where `cycle_count == TIMEOUT_CYCLES-1` and completion is not met → TIMEOUT. If completion and the timeout limit occur on the same edge, completion wins.
- DRAIN: a down-counter loaded with `DRAIN_CYCLES-1` counts to 0, then → DONE. `cycle_count` freezes in DRAIN, DONE and TIMEOUT.
- DONE: `halt`=1. TIMEOUT: `timeout`=1; `core_done` shows which cores finished. Both states hold until `start` or `rst`.
- `sel_cycle` is a combinational mux of `finish[sel_core]`; it is 0 when `sel_core >= NUM_CORES`.
- `rst` asserted mid-RUN or mid-DRAIN → immediate return to IDLE with all values cleared. No partial state survives.

## Timing
- `ins_bus` is sampled on the rising edge. `core_done[i]` is visible one cycle after the ENDOP sample.
- The first RUN sampling edge sees `cycle_count`=0, so a core showing ENDOP there records finish=0.
- `all_done` is high during the cycle after the completing edge. `halt` rises DRAIN_CYCLES cycles after `all_done` rises (same cycle when DRAIN_CYCLES=0).
- `busy` rises the cycle after `start` and falls when `halt` or `timeout` rises.
- `timeout` rises exactly TIMEOUT_CYCLES cycles after `busy` rises.
- Latency from the last ENDOP sample to `halt`: 1+DRAIN_CYCLES cycles.

## Test plan
- Reset check: assert `rst` mid-run → all outputs 0 immediately. After release, the FSM is IDLE and `start` is needed to run.
- Staggered finish (defaults): cores 0..3 present 28 at RUN cycles 10, 40, 25, 60 → `core_done` builds 0001, 0101, 0111, 1111. `sel_cycle` reads 10/40/25/60 for sel 0..3 (sel 5 → 0). `all_done` pulses once, `halt` rises 5 cycles later, and `cycle_count` freezes at 61.
- Simultaneous finish: all cores present 28 on the first RUN edge → every finish=0, `all_done` next cycle. Separately, ENDOP held for 10 cycles, then other values → flags stay sticky and `finish` is not overwritten.
- Timeout (TIMEOUT_CYCLES=50): core 3 never shows 28 → `timeout` rises 50 cycles after `busy`, `core_done`=0111, `halt`=0. With core 3 finishing exactly at cycle 49 → DRAIN/DONE, no timeout.
- DRAIN_CYCLES=0 with NUM_CORES=8: `halt` and `all_done` rise together. `start` during DRAIN (defaults) is ignored. `start` in DONE restarts with everything cleared.
